// File: rtl/sr_readback_stream_if.sv
// sr_readback_stream_if: FIFO write port (master drives fifo_data/fifo_wr_en, slave drives fifo_full)
interface sr_readback_stream_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_wr_en;
  modport master (output fifo_data, output fifo_wr_en, input fifo_full);
  modport slave (input fifo_data, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/sr_readback_stream.sv
// sr_readback_stream: oversampled SR readback to FIFO words (clock/reset, enable, sr_ck1/sr_ck2/sr_ld/sr_sout in, fifo port, bit_count/error_count/busy/done/overflow out)
module sr_readback_stream #(
  parameter int DATA_W      = 64,
  parameter int SR_LEN      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sr_ck1,
  input  logic                        sr_ck2,
  input  logic                        sr_ld,
  input  logic                        sr_sout,
  sr_readback_stream_if.master        fifo,
  output logic [15:0]                 bit_count,
  output logic [15:0]                 error_count,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);
  localparam int WW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, CAPTURE, FLUSH, TRAILER, DRAIN} state_t;
  state_t            state;
  logic [3:0]        sy [SYNC_STAGES];
  logic [2:0]        d;
  logic [3:0]        q;
  logic              s1, hold_v, sout, fall1, fall2, rise_ld, pop;
  logic [DATA_W-1:0] word, hold, shifted;
  logic [WW-1:0]     wcnt;
  assign q       = sy[SYNC_STAGES-1];
  assign sout    = q[3];
  assign fall1   = d[0] & ~q[0];
  assign fall2   = d[1] & ~q[1];
  assign rise_ld = ~d[2] & q[2];
  assign shifted = {word[DATA_W-2:0], sout};
  assign pop     = hold_v & ~fifo.fifo_full;
  assign busy    = state != IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sy[i] <= '0;
      d               <= '0;
      s1              <= 1'b0;
      state           <= IDLE;
      word            <= '0;
      hold            <= '0;
      hold_v          <= 1'b0;
      wcnt            <= '0;
      bit_count       <= '0;
      error_count     <= '0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      fifo.fifo_wr_en <= 1'b0;
      fifo.fifo_data  <= '0;
    end else begin
      sy[0] <= {sr_sout, sr_ld, sr_ck2, sr_ck1};
      for (int i = 1; i < SYNC_STAGES; i++) sy[i] <= sy[i-1];
      d               <= q[2:0];
      done            <= 1'b0;
      fifo.fifo_wr_en <= pop;
      if (pop) begin
        fifo.fifo_data <= hold;
        hold_v         <= 1'b0;
      end
      if (fall1) s1 <= sout;
      case (state)
        IDLE:
          if (enable) begin
            bit_count   <= '0;
            error_count <= '0;
            wcnt        <= '0;
            word        <= '0;
            overflow    <= 1'b0;
            state       <= CAPTURE;
          end
        CAPTURE: begin
          if (fall2) begin
            // s1 here is the value from before any coincident fall1 update
            if (sout != s1 && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            word      <= shifted;
            bit_count <= bit_count + 16'd1;
            if (wcnt == WW'(DATA_W-1)) begin
              wcnt <= '0;
              if (pop || !hold_v) begin
                hold   <= shifted;
                hold_v <= 1'b1;
              end else overflow <= 1'b1;
            end else wcnt <= wcnt + WW'(1);
          end
          if (rise_ld || (fall2 && bit_count == 16'(SR_LEN-1))) state <= FLUSH;
        end
        FLUSH:
          if (wcnt == '0) state <= TRAILER;
          else if (!hold_v) begin
            hold   <= word << (DATA_W - int'(wcnt));
            hold_v <= 1'b1;
            state  <= TRAILER;
          end
        TRAILER:
          if (!hold_v) begin
            hold   <= DATA_W'({16'hEB5A, error_count, bit_count});
            hold_v <= 1'b1;
            state  <= DRAIN;
          end
        DRAIN:
          if (pop) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sr_readback_stream.sv
// tb_sr_readback_stream: scoreboard bench for sr_readback_stream (SR_LEN=1024 and SR_LEN=70 instances)
module tb_sr_readback_stream;
  logic clock = 1'b0, reset = 1'b1, en_a = 1'b0, en_b = 1'b0;
  logic sr_ck1 = 1'b0, sr_ck2 = 1'b0, sr_ld = 1'b0, sr_sout = 1'b0;
  logic [15:0] bc_a, ec_a, bc_b, ec_b;
  logic busy_a, done_a, ov_a, busy_b, done_b, ov_b;
  logic [63:0] qa[$], qb[$];
  int compared = 0, mismatched = 0;
  int wr_a = 0, wr_b = 0, dn_a = 0, dn_b = 0;
  logic [63:0] acc;
  int n, tot, errs, widx, keep_limit, len, sel;
  logic ms1 = 1'b0;
  bit ended;
  always #5 clock = ~clock;
  sr_readback_stream_if #(.DATA_W(64)) fa();
  sr_readback_stream_if #(.DATA_W(64)) fb();
  sr_readback_stream #(.DATA_W(64), .SR_LEN(1024), .SYNC_STAGES(2)) u_a (
    .clock(clock), .reset(reset), .enable(en_a), .sr_ck1(sr_ck1), .sr_ck2(sr_ck2),
    .sr_ld(sr_ld), .sr_sout(sr_sout), .fifo(fa.master), .bit_count(bc_a),
    .error_count(ec_a), .busy(busy_a), .done(done_a), .overflow(ov_a));
  sr_readback_stream #(.DATA_W(64), .SR_LEN(70), .SYNC_STAGES(2)) u_b (
    .clock(clock), .reset(reset), .enable(en_b), .sr_ck1(sr_ck1), .sr_ck2(sr_ck2),
    .sr_ld(sr_ld), .sr_sout(sr_sout), .fifo(fb.master), .bit_count(bc_b),
    .error_count(ec_b), .busy(busy_b), .done(done_b), .overflow(ov_b));
  always @(negedge clock) begin
    logic [63:0] e;
    if (done_a) dn_a++;
    if (done_b) dn_b++;
    if (fa.fifo_wr_en) begin
      wr_a++;
      compared++;
      if (qa.size() == 0) begin
        mismatched++;
        $display("FAIL word_a unexpected write got=%h", fa.fifo_data);
      end else begin
        e = qa.pop_front();
        if (fa.fifo_data !== e) begin
          mismatched++;
          $display("FAIL word_a got=%h exp=%h", fa.fifo_data, e);
        end
      end
    end
    if (fb.fifo_wr_en) begin
      wr_b++;
      compared++;
      if (qb.size() == 0) begin
        mismatched++;
        $display("FAIL word_b unexpected write got=%h", fb.fifo_data);
      end else begin
        e = qb.pop_front();
        if (fb.fifo_data !== e) begin
          mismatched++;
          $display("FAIL word_b got=%h exp=%h", fb.fifo_data, e);
        end
      end
    end
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge clock);
  endtask
  task automatic push_exp(input logic [63:0] w);
    if (sel == 1) qb.push_back(w);
    else qa.push_back(w);
  endtask
  task automatic model_end();
    if (n > 0) push_exp(acc << (64 - n));
    push_exp({16'h0, 16'hEB5A, errs[15:0], tot[15:0]});
    ended = 1'b1;
  endtask
  task automatic model_bit(input logic b, input logic mis);
    if (!ended) begin
      if (mis) errs++;
      acc = {acc[62:0], b};
      n++;
      tot++;
      if (n == 64) begin
        if (widx < keep_limit) push_exp(acc);
        widx++;
        n = 0;
        acc = '0;
      end
      if (tot == len) model_end();
    end
  endtask
  task automatic start(input int s, input int l);
    sel = s; len = l; acc = '0; n = 0; tot = 0; errs = 0; widx = 0;
    keep_limit = 1 << 30; ended = 1'b0;
    if (s == 1) en_b = 1'b1;
    else en_a = 1'b1;
    cyc(1);
    en_a = 1'b0;
    en_b = 1'b0;
    cyc(2);
  endtask
  // mode 0: clean bit, 1: sout flips between fall1 and fall2, 2: ck1/ck2 fall together
  task automatic send_bit(input logic b, input int mode);
    sr_sout = b;
    cyc(6);
    if (mode == 2) begin
      sr_ck1 = 1'b1;
      sr_ck2 = 1'b1;
      cyc(6);
      model_bit(b, b != ms1);
      ms1 = b;
      sr_ck1 = 1'b0;
      sr_ck2 = 1'b0;
      cyc(6);
    end else begin
      sr_ck1 = 1'b1;
      cyc(6);
      sr_ck1 = 1'b0;
      ms1 = b;
      cyc(6);
      if (mode == 1) sr_sout = ~b;
      cyc(6);
      sr_ck2 = 1'b1;
      cyc(6);
      model_bit(mode == 1 ? ~b : b, mode == 1);
      sr_ck2 = 1'b0;
      cyc(6);
    end
  endtask
  task automatic pulse_ld();
    if (!ended) model_end();
    sr_ld = 1'b1;
    cyc(6);
    sr_ld = 1'b0;
    cyc(6);
  endtask
  task automatic wait_idle(input string nm);
    int k = 0;
    cyc(2);
    while ((sel == 1 ? busy_b : busy_a) && k < 3000) begin
      cyc(1);
      k++;
    end
    compared++;
    if (k >= 3000) begin
      mismatched++;
      $display("FAIL %s idle_timeout busy still high after %0d cycles", nm, k);
    end
    cyc(4);
    compared++;
    if ((sel == 1 ? qb.size() : qa.size()) != 0) begin
      mismatched++;
      $display("FAIL %s pending_words got=%0d exp=0", nm, sel == 1 ? qb.size() : qa.size());
    end
  endtask
  task automatic check_zero(input string nm);
    compared++;
    if ({bc_a, ec_a, busy_a, done_a, ov_a, fa.fifo_wr_en, fa.fifo_data} !== '0) begin
      mismatched++;
      $display("FAIL %s outputs_a bc=%h ec=%h busy=%b done=%b ov=%b wr=%b data=%h exp all 0",
               nm, bc_a, ec_a, busy_a, done_a, ov_a, fa.fifo_wr_en, fa.fifo_data);
    end
    compared++;
    if ({bc_b, ec_b, busy_b, done_b, ov_b, fb.fifo_wr_en, fb.fifo_data} !== '0) begin
      mismatched++;
      $display("FAIL %s outputs_b bc=%h ec=%h busy=%b done=%b ov=%b wr=%b data=%h exp all 0",
               nm, bc_b, ec_b, busy_b, done_b, ov_b, fb.fifo_wr_en, fb.fifo_data);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    fa.fifo_full = 1'b0;
    fb.fifo_full = 1'b0;
    cyc(4);
    check_zero("reset");
    reset = 1'b0;
    cyc(4);
  endtask
  task automatic test_basic();
    logic [63:0] v = 64'hDEADBEEF_01234567;
    int w0 = wr_a, d0 = dn_a;
    start(0, 1024);
    for (int i = 63; i >= 0; i--) send_bit(v[i], 0);
    pulse_ld();
    wait_idle("basic");
    compared++;
    if (wr_a - w0 != 2) begin
      mismatched++;
      $display("FAIL basic writes got=%0d exp=2", wr_a - w0);
    end
    compared++;
    if (dn_a - d0 != 1) begin
      mismatched++;
      $display("FAIL basic done_pulses got=%0d exp=1", dn_a - d0);
    end
    compared++;
    if (bc_a !== 16'd64) begin
      mismatched++;
      $display("FAIL basic bit_count got=%0d exp=64", bc_a);
    end
  endtask
  task automatic test_ones_100();
    int w0 = wr_a;
    start(0, 1024);
    for (int i = 0; i < 100; i++) send_bit(1'b1, 0);
    pulse_ld();
    wait_idle("ones100");
    compared++;
    if (wr_a - w0 != 3) begin
      mismatched++;
      $display("FAIL ones100 writes got=%0d exp=3", wr_a - w0);
    end
    compared++;
    if (bc_a !== 16'd100) begin
      mismatched++;
      $display("FAIL ones100 bit_count got=%0d exp=100", bc_a);
    end
  endtask
  task automatic test_errors();
    logic [11:0] p = 12'hA5C;
    start(0, 1024);
    for (int i = 0; i < 12; i++) send_bit(p[i], (i == 3 || i == 10) ? 1 : 0);
    pulse_ld();
    wait_idle("errors");
    compared++;
    if (ec_a !== 16'd2) begin
      mismatched++;
      $display("FAIL errors error_count got=%0d exp=2", ec_a);
    end
  endtask
  task automatic test_coincident();
    start(0, 1024);
    send_bit(1'b1, 0);
    send_bit(1'b0, 2);
    send_bit(1'b0, 2);
    pulse_ld();
    wait_idle("coincident");
    compared++;
    if (ec_a !== 16'd1) begin
      mismatched++;
      $display("FAIL coincident error_count got=%0d exp=1", ec_a);
    end
  endtask
  task automatic test_full_flush();
    int w0;
    start(0, 1024);
    for (int i = 0; i < 70; i++) send_bit(1'($urandom_range(0, 1)), 0);
    fa.fifo_full = 1'b1;
    cyc(2);
    w0 = wr_a;
    pulse_ld();
    cyc(200);
    compared++;
    if (wr_a != w0) begin
      mismatched++;
      $display("FAIL full_flush writes_while_full got=%0d exp=0", wr_a - w0);
    end
    fa.fifo_full = 1'b0;
    wait_idle("full_flush");
    compared++;
    if (ov_a !== 1'b0) begin
      mismatched++;
      $display("FAIL full_flush overflow got=%b exp=0", ov_a);
    end
  endtask
  task automatic test_overflow();
    int w0;
    start(0, 1024);
    keep_limit = 1;
    fa.fifo_full = 1'b1;
    w0 = wr_a;
    for (int i = 0; i < 192; i++) send_bit(1'($urandom_range(0, 1)), 0);
    compared++;
    if (ov_a !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow flag got=%b exp=1", ov_a);
    end
    compared++;
    if (wr_a != w0) begin
      mismatched++;
      $display("FAIL overflow writes_while_full got=%0d exp=0", wr_a - w0);
    end
    fa.fifo_full = 1'b0;
    cyc(5);
    compared++;
    if (wr_a - w0 != 1) begin
      mismatched++;
      $display("FAIL overflow retained_writes got=%0d exp=1", wr_a - w0);
    end
    pulse_ld();
    wait_idle("overflow");
    compared++;
    if (ov_a !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow sticky got=%b exp=1", ov_a);
    end
  endtask
  task automatic test_sr_len();
    int d0 = dn_b, w0 = wr_b;
    start(1, 70);
    for (int i = 0; i < 80; i++) send_bit(1'($urandom_range(0, 1)), 0);
    wait_idle("sr_len");
    compared++;
    if (bc_b !== 16'd70) begin
      mismatched++;
      $display("FAIL sr_len bit_count got=%0d exp=70", bc_b);
    end
    compared++;
    if (wr_b - w0 != 3 || dn_b - d0 != 1) begin
      mismatched++;
      $display("FAIL sr_len writes/done got=%0d/%0d exp=3/1", wr_b - w0, dn_b - d0);
    end
  endtask
  task automatic test_reset_mid();
    int d0 = dn_b, w0 = wr_b;
    start(1, 70);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 0);
    reset = 1'b1;
    cyc(1);
    check_zero("reset_mid");
    reset = 1'b0;
    cyc(100);
    compared++;
    if (wr_b != w0 || dn_b != d0 || busy_b !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid writes/done/busy got=%0d/%0d/%b exp=0/0/0", wr_b - w0, dn_b - d0, busy_b);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_ones_100();
    test_errors();
    test_coincident();
    test_full_flush();
    test_overflow();
    test_sr_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
